hwpe_multistream_job_ctrl: RTL and testbench

// - Parametrised job controller for HWPE accelerators with N_IN input and N_OUT output streams.
// - Sits between hwpe_ctrl_slave (register file, start trigger) and the streamer/engine.
// - Per-job actions: snapshots per-stream address-generator config, starts streams and engine,

---
 rtl/hwpe_multistream_job_ctrl_pkg.sv | 57 +++++
 rtl/hwpe_multistream_job_ctrl_limit_counter.sv | 41 ++++
 rtl/hwpe_multistream_job_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hwpe_multistream_job_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hwpe_multistream_job_ctrl_pkg.sv
// Shared types and constants for the multistream HWPE job controller.
// - stream_cfg_t : per-stream address-generator configuration latched per job
// - state_t      : job controller FSM encoding
// - OFS_*        : word offsets of each field group inside a stream's register block
// - cfg_from_words : assembles a stream_cfg_t from the raw job words
package hwpe_multistream_ctrl_package;

  localparam int unsigned WORDS_PER_STREAM = 5;
  localparam int unsigned OFS_TRANS        = 0;
  localparam int unsigned OFS_LINE         = 1;
  localparam int unsigned OFS_FEAT         = 2;
  localparam int unsigned OFS_STEP         = 3;
  localparam int unsigned OFS_FLAGS        = 4;

  typedef struct packed {
    logic [31:0] trans_size;
    logic [15:0] line_length;
    logic [15:0] line_stride;
    logic [15:0] feat_length;
    logic [15:0] feat_stride;
    logic [15:0] step;
    logic [15:0] feat_roll;
    logic        realign_type;
    logic        loop_outer;
  } stream_cfg_t;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    WAIT_READY,
    START,
    RUN,
    DONE
  } state_t;

  // Upper halves of the packed words carry the length/step field, lower halves the stride/roll.
  function automatic stream_cfg_t cfg_from_words(
    input logic [31:0] w_trans,
    input logic [31:0] w_line,
    input logic [31:0] w_feat,
    input logic [31:0] w_step,
    input logic [1:0]  w_flags
  );
    stream_cfg_t c;
    c.trans_size   = w_trans;
    c.line_length  = w_line[31:16];
    c.line_stride  = w_line[15:0];
    c.feat_length  = w_feat[31:16];
    c.feat_stride  = w_feat[15:0];
    c.step         = w_step[31:16];
    c.feat_roll    = w_step[15:0];
    c.realign_type = w_flags[1];
    c.loop_outer   = w_flags[0];
    return c;
  endfunction

endpackage

// File: rtl/hwpe_multistream_job_ctrl_limit_counter.sv
// Saturating 33-bit output-beat counter for one output stream.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   clear_i      soft clear, same effect as rst_i
//   load_i       capture a new limit (limit_word_i + 1) and restart the count at 0
//   limit_word_i programmed limit word; the effective limit is one more than this
//   en_i         one accepted beat this cycle
//   at_limit_o   count currently equals the limit
//   reach_o      the beat presented this cycle brings the count onto the limit
module hwpe_limit_counter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [31:0] limit_word_i,
  input  logic        en_i,
  output logic        at_limit_o,
  output logic        reach_o
);

  logic [32:0] count;
  logic [32:0] limit;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count <= '0;
      limit <= '0;
    end else if (load_i) begin
      count <= '0;
      // 33 bits so a limit word of all-ones still yields a reachable limit.
      limit <= {1'b0, limit_word_i} + 33'd1;
    end else if (en_i && !at_limit_o) begin
      count <= count + 33'd1;
    end
  end

  assign at_limit_o = (count == limit);
  assign reach_o    = en_i && !at_limit_o && ((count + 33'd1) == limit);

endmodule

// File: rtl/hwpe_multistream_job_ctrl.sv
// Job controller for an HWPE with N_IN source and N_OUT sink streams.
// Latches per-stream address-generator config, starts streams and engine once all
// streams are ready, counts output beats against per-output limits, tracks stream
// completion and signals job end; an optional watchdog ends a stalled job with err_o.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   clear_i            soft clear, same effect as rst_i
//   start_i            job trigger pulse (only honoured in IDLE)
//   regs_i             flattened job words, word k = regs_i[32k +: 32]
//   cfg_o              per-stream config latched at job start
//   req_start_o        one-cycle start pulse to every stream
//   stream_ready_i     per-stream ready
//   stream_done_i      per-stream done pulse
//   engine_start_o     one-cycle engine start pulse
//   out_hs_i           per-output accepted beat
//   busy_o             job in flight (LATCH through DONE)
//   done_o, err_o      one-cycle job end, err_o marks a watchdog-terminated job
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for start_i
// LATCH      | capture cfg and limits, clear sticky done flags
// WAIT_READY | waiting for every stream to report ready
// START      | pulse req_start_o / engine_start_o
// RUN        | count beats and stream dones, watchdog active
// DONE       | done_o (and err_o on timeout) asserted for one cycle
module hwpe_multistream_job_ctrl
  import hwpe_multistream_ctrl_package::*;
#(
  parameter int unsigned N_IN    = 2,
  parameter int unsigned N_OUT   = 1,
  parameter int unsigned TIMEOUT = 0,
  localparam int unsigned N_STREAMS = N_IN + N_OUT,
  localparam int unsigned N_REGS    = WORDS_PER_STREAM * N_STREAMS + N_OUT
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          start_i,
  input  logic [N_REGS*32-1:0]          regs_i,
  output stream_cfg_t [N_STREAMS-1:0]   cfg_o,
  output logic [N_STREAMS-1:0]          req_start_o,
  input  logic [N_STREAMS-1:0]          stream_ready_i,
  input  logic [N_STREAMS-1:0]          stream_done_i,
  output logic                          engine_start_o,
  input  logic [N_OUT-1:0]              out_hs_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o
);

  state_t                 state;
  logic [N_STREAMS-1:0]   done_sticky;
  logic [N_STREAMS-1:0]   done_next;
  logic [31:0]            wd_cnt;
  logic [N_OUT-1:0]       cnt_en;
  logic [N_OUT-1:0]       cnt_at_limit;
  logic [N_OUT-1:0]       cnt_reach;
  logic                   in_run;
  logic                   activity;
  logic                   exit_now;
  logic                   wd_expire;
  logic [30*N_STREAMS-1:0] unused_flag_bits;

  assign in_run = (state == RUN);

  for (genvar o = 0; o < N_OUT; o++) begin : g_cnt
    assign cnt_en[o] = in_run && out_hs_i[o];

    hwpe_limit_counter u_cnt (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clear_i      (clear_i),
      .load_i       (state == LATCH),
      .limit_word_i (regs_i[32*(WORDS_PER_STREAM*N_STREAMS+o) +: 32]),
      .en_i         (cnt_en[o]),
      .at_limit_o   (cnt_at_limit[o]),
      .reach_o      (cnt_reach[o])
    );
  end

  for (genvar s = 0; s < N_STREAMS; s++) begin : g_flags
    assign unused_flag_bits[30*s +: 30] = regs_i[32*(WORDS_PER_STREAM*s+OFS_FLAGS)+2 +: 30];
  end

  // Exit looks at this cycle's beats and dones so a final beat/done lands in DONE next cycle.
  assign done_next = done_sticky | (((state == START) || in_run) ? stream_done_i : '0);
  assign exit_now  = in_run && (&(cnt_at_limit | cnt_reach)) && (&done_next);
  assign activity  = (|out_hs_i) || (|stream_done_i);
  assign wd_expire = (TIMEOUT != 0) && in_run && !activity && (wd_cnt == 32'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state          <= IDLE;
      cfg_o          <= '0;
      req_start_o    <= '0;
      engine_start_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      done_sticky    <= '0;
      wd_cnt         <= '0;
    end else begin
      req_start_o    <= '0;
      engine_start_o <= 1'b0;
      done_o         <= 1'b0;
      err_o          <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= LATCH;
            busy_o <= 1'b1;
          end
        end
        LATCH: begin
          for (int s = 0; s < N_STREAMS; s++) begin
            cfg_o[s] <= cfg_from_words(
              regs_i[32*(WORDS_PER_STREAM*s+OFS_TRANS) +: 32],
              regs_i[32*(WORDS_PER_STREAM*s+OFS_LINE)  +: 32],
              regs_i[32*(WORDS_PER_STREAM*s+OFS_FEAT)  +: 32],
              regs_i[32*(WORDS_PER_STREAM*s+OFS_STEP)  +: 32],
              regs_i[32*(WORDS_PER_STREAM*s+OFS_FLAGS) +: 2]);
          end
          done_sticky <= '0;
          state       <= WAIT_READY;
        end
        WAIT_READY: begin
          if (&stream_ready_i) begin
            req_start_o    <= '1;
            engine_start_o <= 1'b1;
            state          <= START;
          end
        end
        START: begin
          done_sticky <= done_next;
          wd_cnt      <= TIMEOUT;
          state       <= RUN;
        end
        RUN: begin
          done_sticky <= done_next;
          if (exit_now) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else if (wd_expire) begin
            done_o <= 1'b1;
            err_o  <= 1'b1;
            state  <= DONE;
          end else if (activity) begin
            wd_cnt <= TIMEOUT;
          end else if (wd_cnt != 32'd0) begin
            wd_cnt <= wd_cnt - 32'd1;
          end
        end
        DONE: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hwpe_multistream_job_ctrl.sv
module tb_hwpe_multistream_job_ctrl;
  import hwpe_multistream_ctrl_package::*;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              clear_i;
  logic              start_i;
  logic [16*32-1:0]  regs_i;
  stream_cfg_t [2:0] cfg_o;
  logic [2:0]        req_start_o;
  logic [2:0]        stream_ready_i;
  logic [2:0]        stream_done_i;
  logic              engine_start_o;
  logic [0:0]        out_hs_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  int n_tests = 0;
  int n_fail  = 0;

  stream_cfg_t exp0;
  stream_cfg_t exp2;

  hwpe_multistream_job_ctrl #(
    .N_IN(2), .N_OUT(1), .TIMEOUT(8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .clear_i        (clear_i),
    .start_i        (start_i),
    .regs_i         (regs_i),
    .cfg_o          (cfg_o),
    .req_start_o    (req_start_o),
    .stream_ready_i (stream_ready_i),
    .stream_done_i  (stream_done_i),
    .engine_start_o (engine_start_o),
    .out_hs_i       (out_hs_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // start pulse, LATCH, WAIT_READY, START, then into RUN (all streams ready)
  task automatic run_to_run();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    tick();
  endtask

  // n consecutive beats; stream s gets its done pulse on beat d_s (0 = never)
  task automatic run_beats(input int n, input int d0, input int d1, input int d2);
    for (int i = 1; i <= n; i++) begin
      out_hs_i         = 1'b1;
      stream_done_i[0] = (i == d0);
      stream_done_i[1] = (i == d1);
      stream_done_i[2] = (i == d2);
      tick();
      if (i < n) check("early_done", 160'(done_o), 160'(1'b0));
    end
    out_hs_i      = 1'b0;
    stream_done_i = '0;
  endtask

  initial begin
    rst_i          = 1'b1;
    clear_i        = 1'b0;
    start_i        = 1'b0;
    stream_ready_i = 3'b111;
    stream_done_i  = '0;
    out_hs_i       = 1'b0;
    regs_i         = '0;
    regs_i[0*32 +: 32]  = 32'h0000_0100;
    regs_i[1*32 +: 32]  = 32'h0010_0020;
    regs_i[2*32 +: 32]  = 32'h0030_0040;
    regs_i[3*32 +: 32]  = 32'h0050_0060;
    regs_i[4*32 +: 32]  = 32'hFFFF_FFFE;
    regs_i[5*32 +: 32]  = 32'hDEAD_BEEF;
    regs_i[10*32 +: 32] = 32'h0000_2000;
    regs_i[11*32 +: 32] = 32'h0001_0002;
    regs_i[12*32 +: 32] = 32'h0003_0004;
    regs_i[13*32 +: 32] = 32'h0005_0006;
    regs_i[14*32 +: 32] = 32'h0000_0001;
    regs_i[15*32 +: 32] = 32'd15;

    exp0 = '0;
    exp0.trans_size = 32'h100;  exp0.line_length = 16'h10; exp0.line_stride = 16'h20;
    exp0.feat_length = 16'h30;  exp0.feat_stride = 16'h40; exp0.step = 16'h50;
    exp0.feat_roll = 16'h60;    exp0.realign_type = 1'b1;  exp0.loop_outer = 1'b0;
    exp2 = '0;
    exp2.trans_size = 32'h2000; exp2.line_length = 16'h1;  exp2.line_stride = 16'h2;
    exp2.feat_length = 16'h3;   exp2.feat_stride = 16'h4;  exp2.step = 16'h5;
    exp2.feat_roll = 16'h6;     exp2.realign_type = 1'b0;  exp2.loop_outer = 1'b1;

    tick();
    tick();
    rst_i = 1'b0;
    check("rst_busy", 160'(busy_o), 160'(1'b0));
    check("rst_done", 160'(done_o), 160'(1'b0));
    check("rst_err", 160'(err_o), 160'(1'b0));
    check("rst_req", 160'(req_start_o), 160'(3'b000));
    check("rst_eng", 160'(engine_start_o), 160'(1'b0));
    check("rst_cfg", 160'(cfg_o), 160'(0));

    // Job 1: latency and basic completion
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("j1_busy_latch", 160'(busy_o), 160'(1'b1));
    check("j1_req_t1", 160'(req_start_o), 160'(3'b000));
    tick();
    check("j1_req_t2", 160'(req_start_o), 160'(3'b000));
    check("j1_cfg0", 160'(cfg_o[0]), 160'(exp0));
    check("j1_cfg2", 160'(cfg_o[2]), 160'(exp2));
    check("j1_cfg1_trans", 160'(cfg_o[1].trans_size), 160'(32'hDEAD_BEEF));
    tick();
    check("j1_req_t3", 160'(req_start_o), 160'(3'b111));
    check("j1_eng_t3", 160'(engine_start_o), 160'(1'b1));
    tick();
    check("j1_req_off", 160'(req_start_o), 160'(3'b000));
    check("j1_eng_off", 160'(engine_start_o), 160'(1'b0));
    run_beats(16, 5, 10, 16);
    check("j1_done", 160'(done_o), 160'(1'b1));
    check("j1_err", 160'(err_o), 160'(1'b0));
    check("j1_busy_done", 160'(busy_o), 160'(1'b1));
    tick();
    check("j1_done_pulse", 160'(done_o), 160'(1'b0));
    check("j1_busy_end", 160'(busy_o), 160'(1'b0));

    // Job 2: stream 1 not ready for 10 cycles, regs rewritten mid-run
    stream_ready_i = 3'b101;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      check("j2_wait_req", 160'(req_start_o), 160'(3'b000));
    end
    check("j2_wait_busy", 160'(busy_o), 160'(1'b1));
    stream_ready_i = 3'b111;
    tick();
    check("j2_req", 160'(req_start_o), 160'(3'b111));
    tick();
    regs_i[0*32 +: 32] = 32'hFFFF_0000;
    run_beats(16, 1, 2, 0);
    check("j2_no_done_missing", 160'(done_o), 160'(1'b0));
    check("j2_cfg_hold", 160'(cfg_o[0].trans_size), 160'(32'h100));
    stream_done_i = 3'b100;
    tick();
    stream_done_i = '0;
    check("j2_done", 160'(done_o), 160'(1'b1));
    check("j2_err", 160'(err_o), 160'(1'b0));
    tick();

    // Job 3: 20 beats against limit 16, last beat with last stream done
    run_to_run();
    check("j3_cfg_new", 160'(cfg_o[0].trans_size), 160'(32'hFFFF_0000));
    run_beats(20, 3, 8, 20);
    check("j3_done", 160'(done_o), 160'(1'b1));
    check("j3_err", 160'(err_o), 160'(1'b0));
    tick();

    // Job 4: watchdog after traffic stops, start_i during RUN ignored
    run_to_run();
    run_beats(4, 1, 0, 0);
    stream_done_i = 3'b010;
    tick();
    stream_done_i = '0;
    for (int k = 1; k <= 8; k++) begin
      start_i = (k == 2);
      tick();
      if (k < 8) check("j4_wd_early", 160'(done_o), 160'(1'b0));
    end
    start_i = 1'b0;
    check("j4_done", 160'(done_o), 160'(1'b1));
    check("j4_err", 160'(err_o), 160'(1'b1));
    tick();
    check("j4_busy_end", 160'(busy_o), 160'(1'b0));
    tick();
    check("j4_start_ignored", 160'(busy_o), 160'(1'b0));

    // Job 5: clear mid-run, then a clean job
    run_to_run();
    run_beats(3, 0, 0, 0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("j5_clr_busy", 160'(busy_o), 160'(1'b0));
    check("j5_clr_done", 160'(done_o), 160'(1'b0));
    check("j5_clr_cfg", 160'(cfg_o), 160'(0));
    tick();
    check("j5_clr_done2", 160'(done_o), 160'(1'b0));
    run_to_run();
    run_beats(16, 1, 2, 16);
    check("j5_done", 160'(done_o), 160'(1'b1));
    check("j5_err", 160'(err_o), 160'(1'b0));
    tick();
    check("j5_busy_end", 160'(busy_o), 160'(1'b0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
